// File: rtl/jpeg_pkg.sv
// Shared JPEG marker constants, DHT writer state encoding and canonical code type.
// Also hosts the DHT segment header byte selector.
package jpeg_pkg;

    localparam logic [7:0]  M_PREFIX    = 8'hFF;
    localparam logic [7:0]  M_SOI       = 8'hD8;
    localparam logic [7:0]  M_DHT       = 8'hC4;
    localparam logic [15:0] DHT_LH_BASE = 16'd19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_HDR   = 3'd2,
        S_BITS  = 3'd3,
        S_VALS  = 3'd4,
        S_DONE  = 3'd5
    } dht_wr_state_t;

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
    } huff_code_t;

    // Byte at position pos of the 5-byte segment header FF C4 Lh Tc/Th.
    function automatic logic [7:0] dht_hdr_byte(input logic [2:0] pos,
                                                input logic [15:0] lh,
                                                input logic [7:0] tcth);
        logic [7:0] b;
        case (pos)
            3'd0:    b = M_PREFIX;
            3'd1:    b = M_DHT;
            3'd2:    b = lh[15:8];
            3'd3:    b = lh[7:0];
            3'd4:    b = tcth;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dht_canon_gen.sv
// Canonical Huffman code walker: length pointer, remaining count and running code.
// The same adder serves the table check (code + cnt) and symbol coding (code + 1).
module dht_canon_gen
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0][7:0] cnt,
    input  logic             init,
    input  logic             chk_en,
    input  logic             adv_en,
    input  logic             skip_en,
    output logic [15:0]      code_val,
    output logic [4:0]       code_len,
    output logic             skip,
    output logic             ovf,
    output logic             stall_after
);

    logic [16:0] code_r;
    logic [4:0]  len_r;
    logic [7:0]  rem_r;
    logic [7:0]  cnt_cur_s;
    logic [7:0]  cnt_next_s;
    logic [17:0] add_b_s;
    logic [17:0] sum_s;

    assign cnt_cur_s   = cnt[len_r[3:0] - 4'd1];
    assign cnt_next_s  = cnt[len_r[3:0]];
    assign add_b_s     = chk_en ? {10'd0, cnt_cur_s} : 18'd1;
    assign sum_s       = {1'b0, code_r} + add_b_s;
    assign ovf         = (cnt_cur_s != 8'd0) && (sum_s >= (18'd1 << len_r));
    assign skip        = (rem_r == 8'd0);
    assign stall_after = (rem_r == 8'd1) && (cnt_next_s == 8'd0);
    assign code_val    = code_r[15:0];
    assign code_len    = len_r;

    // Walk state: init, check step, symbol advance or empty-length skip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= 17'd0;
            len_r  <= 5'd0;
            rem_r  <= 8'd0;
        end else if (init) begin
            code_r <= 17'd0;
            len_r  <= 5'd1;
            rem_r  <= cnt[0];
        end else if (chk_en) begin
            code_r <= {sum_s[15:0], 1'b0};
            len_r  <= len_r + 5'd1;
        end else if (adv_en) begin
            if (rem_r == 8'd1) begin
                code_r <= {sum_s[15:0], 1'b0};
                len_r  <= len_r + 5'd1;
                rem_r  <= cnt_next_s;
            end else begin
                code_r <= sum_s[16:0];
                rem_r  <= rem_r - 8'd1;
            end
        end else if (skip_en) begin
            code_r <= {code_r[15:0], 1'b0};
            len_r  <= len_r + 5'd1;
            rem_r  <= cnt_next_s;
        end else begin
            code_r <= code_r;
        end
    end

endmodule

// File: rtl/dht_segment_writer.sv
// Validates a loaded Huffman table and streams its DHT marker segment,
// emitting each symbol's canonical code alongside the HUFFVAL bytes.
module dht_segment_writer
    import jpeg_pkg::*;
#(
    parameter int MAX_SYMS  = 256,
    parameter int SYM_IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bits_we,
    input  logic [3:0]           bits_idx,
    input  logic [7:0]           bits_val,
    input  logic                 val_we,
    input  logic [SYM_IDX_W-1:0] val_idx,
    input  logic [7:0]           val_data,
    input  logic                 start,
    input  logic [3:0]           tc,
    input  logic [3:0]           th,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 code_we,
    output logic [7:0]           code_sym,
    output logic [15:0]          code_val,
    output logic [4:0]           code_len
);

    localparam logic [12:0] MAX_N = 13'(MAX_SYMS);

    dht_wr_state_t        state_r, state_nxt;
    logic [15:0][7:0]     cnt_r;
    logic [7:0]           huffval_r [MAX_SYMS];
    logic [7:0]           tcth_r, tcth_nxt;
    logic [3:0]           idx_r, idx_nxt;
    logic [11:0]          nsym_r, nsym_nxt;
    logic                 err_acc_r, err_acc_nxt;
    logic [SYM_IDX_W-1:0] vidx_r, vidx_nxt;
    logic                 busy_r, busy_nxt, done_r, done_nxt, err_r, err_nxt;
    logic                 out_valid_r, out_valid_nxt, out_last_r, out_last_nxt;
    logic [7:0]           out_data_r, out_data_nxt;
    logic                 code_we_r, code_we_nxt;
    logic [7:0]           code_sym_r, code_sym_nxt;
    huff_code_t           code_r, code_nxt;

    logic                 hs_s, chk_bad_s;
    logic [3:0]           idx_inc_s;
    logic [11:0]          nsym_sum_s, vpos_s;
    logic [15:0]          lh_s;
    logic [SYM_IDX_W-1:0] vidx_inc_s;
    logic                 cg_init_s, cg_chk_s, cg_adv_s, cg_skip_en_s;
    logic [15:0]          cg_code_s;
    logic [4:0]           cg_len_s;
    logic                 cg_skip_s, cg_ovf_s, cg_stall_s;

    assign hs_s       = out_valid_r && out_ready;
    assign idx_inc_s  = idx_r + 4'd1;
    assign nsym_sum_s = nsym_r + {4'd0, cnt_r[idx_r]};
    assign lh_s       = DHT_LH_BASE + {4'd0, nsym_r};
    assign vpos_s     = 12'(vidx_r) + 12'd1;
    assign vidx_inc_s = vidx_r + SYM_IDX_W'(1);
    assign chk_bad_s  = err_acc_r || cg_ovf_s || (nsym_sum_s == 12'd0)
                        || ({1'b0, nsym_sum_s} > MAX_N);

    dht_canon_gen u_canon (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt_r),
        .init        (cg_init_s),
        .chk_en      (cg_chk_s),
        .adv_en      (cg_adv_s),
        .skip_en     (cg_skip_en_s),
        .code_val    (cg_code_s),
        .code_len    (cg_len_s),
        .skip        (cg_skip_s),
        .ovf         (cg_ovf_s),
        .stall_after (cg_stall_s)
    );

    // BITS counts: writable only while idle, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if ((state_r == S_IDLE) && bits_we) begin
            cnt_r[bits_idx] <= bits_val;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // HUFFVAL store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if ((state_r == S_IDLE) && val_we) begin
            huffval_r[val_idx] <= val_data;
        end
    end

    // Next-state and next-output logic for the segment writer.
    always_comb begin
        state_nxt     = state_r;
        tcth_nxt      = tcth_r;
        idx_nxt       = idx_r;
        nsym_nxt      = nsym_r;
        err_acc_nxt   = err_acc_r;
        vidx_nxt      = vidx_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        out_valid_nxt = out_valid_r;
        out_data_nxt  = out_data_r;
        out_last_nxt  = out_last_r;
        code_we_nxt   = 1'b0;
        code_sym_nxt  = code_sym_r;
        code_nxt      = code_r;
        cg_init_s     = 1'b0;
        cg_chk_s      = 1'b0;
        cg_adv_s      = 1'b0;
        cg_skip_en_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_CHECK;
                    busy_nxt    = 1'b1;
                    tcth_nxt    = {tc, th};
                    idx_nxt     = 4'd0;
                    nsym_nxt    = 12'd0;
                    err_acc_nxt = 1'b0;
                    cg_init_s   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                cg_chk_s    = 1'b1;
                nsym_nxt    = nsym_sum_s;
                err_acc_nxt = err_acc_r || cg_ovf_s;
                idx_nxt     = idx_inc_s;
                if (idx_r == 4'd15) begin
                    if (chk_bad_s) begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt     = S_HDR;
                        idx_nxt       = 4'd0;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = M_PREFIX;
                        out_last_nxt  = 1'b0;
                    end
                end else begin
                    state_nxt = S_CHECK;
                end
            end
            S_HDR: begin
                if (hs_s) begin
                    if (idx_r == 4'd4) begin
                        state_nxt    = S_BITS;
                        idx_nxt      = 4'd0;
                        out_data_nxt = cnt_r[0];
                    end else begin
                        idx_nxt      = idx_inc_s;
                        out_data_nxt = dht_hdr_byte(idx_inc_s[2:0], lh_s, tcth_r);
                    end
                end else begin
                    state_nxt = S_HDR;
                end
            end
            S_BITS: begin
                if (hs_s) begin
                    if (idx_r == 4'd15) begin
                        // Present HUFFVAL[0] at once unless length 1 is empty.
                        state_nxt     = S_VALS;
                        vidx_nxt      = '0;
                        cg_init_s     = 1'b1;
                        out_valid_nxt = (cnt_r[0] != 8'd0);
                        out_data_nxt  = huffval_r[0];
                        out_last_nxt  = (nsym_r == 12'd1);
                    end else begin
                        idx_nxt      = idx_inc_s;
                        out_data_nxt = cnt_r[idx_inc_s];
                    end
                end else begin
                    state_nxt = S_BITS;
                end
            end
            S_VALS: begin
                if (out_valid_r) begin
                    if (out_ready) begin
                        cg_adv_s     = 1'b1;
                        code_we_nxt  = 1'b1;
                        code_sym_nxt = out_data_r;
                        code_nxt     = '{code: cg_code_s, len: cg_len_s};
                        if (out_last_r) begin
                            state_nxt     = S_DONE;
                            done_nxt      = 1'b1;
                            busy_nxt      = 1'b0;
                            out_valid_nxt = 1'b0;
                            out_last_nxt  = 1'b0;
                        end else if (cg_stall_s) begin
                            vidx_nxt      = vidx_inc_s;
                            out_valid_nxt = 1'b0;
                            out_last_nxt  = 1'b0;
                        end else begin
                            vidx_nxt     = vidx_inc_s;
                            out_data_nxt = huffval_r[vidx_inc_s];
                            out_last_nxt = ((vpos_s + 12'd1) == nsym_r);
                        end
                    end else begin
                        out_valid_nxt = 1'b1;
                    end
                end else if (cg_skip_s) begin
                    cg_skip_en_s = 1'b1;
                end else begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = huffval_r[vidx_r];
                    out_last_nxt  = (vpos_s == nsym_r);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            tcth_r      <= 8'd0;
            idx_r       <= 4'd0;
            nsym_r      <= 12'd0;
            err_acc_r   <= 1'b0;
            vidx_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
            code_we_r   <= 1'b0;
            code_sym_r  <= 8'd0;
            code_r      <= '0;
        end else begin
            state_r     <= state_nxt;
            tcth_r      <= tcth_nxt;
            idx_r       <= idx_nxt;
            nsym_r      <= nsym_nxt;
            err_acc_r   <= err_acc_nxt;
            vidx_r      <= vidx_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
            err_r       <= err_nxt;
            out_valid_r <= out_valid_nxt;
            out_data_r  <= out_data_nxt;
            out_last_r  <= out_last_nxt;
            code_we_r   <= code_we_nxt;
            code_sym_r  <= code_sym_nxt;
            code_r      <= code_nxt;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign code_we   = code_we_r;
    assign code_sym  = code_sym_r;
    assign code_val  = code_r.code;
    assign code_len  = code_r.len;

endmodule

// File: tb/tb_dht_segment_writer.sv
// Directed bench for dht_segment_writer using the standard luminance DC table.
module tb_dht_segment_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bits_we, val_we, start, out_ready;
    logic [3:0]  bits_idx, tc, th;
    logic [7:0]  bits_val, val_idx, val_data;
    logic        busy, done, err, out_valid, out_last, code_we;
    logic [7:0]  out_data, code_sym;
    logic [15:0] code_val;
    logic [4:0]  code_len;

    dht_segment_writer #(.MAX_SYMS(256), .SYM_IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .bits_we(bits_we), .bits_idx(bits_idx), .bits_val(bits_val),
        .val_we(val_we), .val_idx(val_idx), .val_data(val_data),
        .start(start), .tc(tc), .th(th),
        .busy(busy), .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .code_we(code_we), .code_sym(code_sym), .code_val(code_val), .code_len(code_len)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] DC_CNT [16] = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                                           8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [7:0] EXP_DC [33] = '{
        8'hFF, 8'hC4, 8'h00, 8'h1F, 8'h00,
        8'h00, 8'h01, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
        8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
        8'h08, 8'h09, 8'h0A, 8'h0B};
    localparam logic [15:0] EXP_CV [12] = '{16'd0, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6,
                                            16'd14, 16'd30, 16'd62, 16'd126, 16'd254, 16'd510};
    localparam logic [4:0] EXP_CL [12] = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3,
                                           5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};

    int errors = 0;
    int checks = 0;

    logic [7:0]  got_b [$];
    logic        got_l [$];
    logic [7:0]  got_s [$];
    logic [15:0] got_v [$];
    logic [4:0]  got_n [$];
    int first_valid, last_hs, done_cyc, err_cyc, done_n, err_n, stab_bad, busy_c1, busy_fin;

    task automatic load_dc(input bit with_vals);
        for (int i = 0; i < 16; i++) begin
            bits_we  = 1'b1;
            bits_idx = 4'(i);
            bits_val = DC_CNT[i];
            val_we   = with_vals && (i < 12);
            val_idx  = 8'(i);
            val_data = 8'(i);
            @(posedge clk); #1;
        end
        bits_we = 1'b0;
        val_we  = 1'b0;
    endtask

    task automatic load_first(input logic [7:0] c0);
        for (int i = 0; i < 16; i++) begin
            bits_we  = 1'b1;
            bits_idx = 4'(i);
            bits_val = (i == 0) ? c0 : 8'd0;
            @(posedge clk); #1;
        end
        bits_we = 1'b0;
    endtask

    // Start one operation and record everything the DUT emits until done/err settles.
    task automatic run_op(input int pct, input int max_cyc, input int wr_cyc);
        logic       stalled;
        logic [7:0] pd;
        logic       pl;
        int         fin;
        got_b.delete(); got_l.delete(); got_s.delete(); got_v.delete(); got_n.delete();
        first_valid = -1; last_hs = -1; done_cyc = -1; err_cyc = -1;
        done_n = 0; err_n = 0; stab_bad = 0; busy_fin = -1; fin = -1;
        stalled = 1'b0; pd = 8'd0; pl = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_c1 = int'(busy);
        for (int c = 1; c <= max_cyc; c++) begin
            if (stalled && (!out_valid || out_data !== pd || out_last !== pl)) stab_bad++;
            if (code_we) begin
                got_s.push_back(code_sym); got_v.push_back(code_val); got_n.push_back(code_len);
            end
            if (done) begin done_n++; if (done_cyc < 0) done_cyc = c; busy_fin = int'(busy); fin = c; end
            if (err)  begin err_n++;  if (err_cyc < 0)  err_cyc = c;  busy_fin = int'(busy); fin = c; end
            if (out_valid && first_valid < 0) first_valid = c;
            bits_we  = (c == wr_cyc);
            bits_idx = 4'd1;
            bits_val = 8'd9;
            out_ready = ($urandom_range(99) < pct);
            if (out_valid && out_ready) begin
                got_b.push_back(out_data); got_l.push_back(out_last);
                if (out_last) last_hs = c;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (fin > 0 && c >= fin + 2) break;
            @(posedge clk); #1;
        end
        bits_we   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        logic [42:0] outs;
        outs = {busy, done, err, out_valid, out_data, out_last, code_we, code_sym, code_val, code_len};
        checks++;
        if (outs !== 43'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(100, 60, -1);
        checks++;
        if (err_n !== 1 || got_b.size() !== 0) begin
            errors++; $display("FAIL reset_cnt_cleared: err pulses %0d bytes %0d want 1 and 0", err_n, got_b.size());
        end
    endtask

    task automatic test_dc_stream;
        int nbad;
        load_dc(1'b1);
        tc = 4'd0; th = 4'd0;
        run_op(100, 200, -1);
        checks++;
        if (busy_c1 !== 1) begin errors++; $display("FAIL dc_busy_rise: got %0d want 1", busy_c1); end
        checks++;
        if (first_valid !== 17) begin errors++; $display("FAIL dc_first_valid: cycle %0d want 17", first_valid); end
        nbad = 0;
        for (int i = 0; i < 33; i++) if (got_b[i] !== EXP_DC[i] || got_l[i] !== (i == 32)) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0) begin
            errors++; $display("FAIL dc_bytes: size %0d bad %0d want size 33 bad 0", got_b.size(), nbad);
        end
        nbad = 0;
        for (int i = 0; i < 12; i++)
            if (got_s[i] !== 8'(i) || got_v[i] !== EXP_CV[i] || got_n[i] !== EXP_CL[i]) nbad++;
        checks++;
        if (got_s.size() !== 12 || nbad !== 0) begin
            errors++; $display("FAIL dc_codes: count %0d bad %0d want count 12 bad 0", got_s.size(), nbad);
        end
        checks++;
        if (got_v[11] !== 16'h01FE || got_n[11] !== 5'd9) begin
            errors++; $display("FAIL dc_code_sym11: got %h/%0d want 1fe/9", got_v[11], got_n[11]);
        end
        checks++;
        if (done_n !== 1 || done_cyc !== last_hs + 1) begin
            errors++; $display("FAIL dc_done: pulses %0d at %0d want 1 at %0d", done_n, done_cyc, last_hs + 1);
        end
        checks++;
        if (busy_fin !== 0 || err_n !== 0) begin
            errors++; $display("FAIL dc_busy_fall: busy %0d err %0d want 0 0", busy_fin, err_n);
        end
    endtask

    task automatic test_invalid;
        load_first(8'd2);
        run_op(100, 60, -1);
        checks++;
        if (err_n !== 1 || err_cyc !== 17) begin
            errors++; $display("FAIL inv_err: pulses %0d at %0d want 1 at 17", err_n, err_cyc);
        end
        checks++;
        if (first_valid !== -1 || got_s.size() !== 0 || done_n !== 0) begin
            errors++; $display("FAIL inv_quiet: valid at %0d codes %0d done %0d want -1 0 0",
                               first_valid, got_s.size(), done_n);
        end
        checks++;
        if (busy_fin !== 0) begin errors++; $display("FAIL inv_busy: got %0d want 0", busy_fin); end
    endtask

    task automatic test_zero_then_valid;
        int nbad;
        load_first(8'd0);
        run_op(100, 60, -1);
        checks++;
        if (err_n !== 1 || got_b.size() !== 0) begin
            errors++; $display("FAIL zero_err: pulses %0d bytes %0d want 1 0", err_n, got_b.size());
        end
        load_dc(1'b0);
        tc = 4'd1; th = 4'd3;
        run_op(100, 200, -1);
        nbad = 0;
        for (int i = 0; i < 33; i++)
            if (got_b[i] !== ((i == 4) ? 8'h13 : EXP_DC[i])) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0 || done_n !== 1) begin
            errors++; $display("FAIL zero_recover: size %0d bad %0d done %0d want 33 0 1", got_b.size(), nbad, done_n);
        end
        tc = 4'd0; th = 4'd0;
    endtask

    task automatic test_backpressure;
        int nbad;
        load_dc(1'b0);
        run_op(30, 2000, -1);
        nbad = 0;
        for (int i = 0; i < 33; i++) if (got_b[i] !== EXP_DC[i] || got_l[i] !== (i == 32)) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0) begin
            errors++; $display("FAIL bp_bytes: size %0d bad %0d want 33 0", got_b.size(), nbad);
        end
        checks++;
        if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable: unstable stalls %0d want 0", stab_bad); end
        checks++;
        if (got_s.size() !== 12 || done_n !== 1) begin
            errors++; $display("FAIL bp_codes: count %0d done %0d want 12 1", got_s.size(), done_n);
        end
    endtask

    task automatic test_reset_mid;
        int nhs;
        int bad;
        logic [42:0] outs;
        int nbad;
        load_dc(1'b0);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nhs = 0;
        for (int c = 1; c < 400 && nhs < 25; c++) begin
            if (out_valid) nhs++;
            @(posedge clk); #1;
        end
        checks++;
        if (nhs !== 25) begin errors++; $display("FAIL mid_reach25: handshakes %0d want 25", nhs); end
        rst_n = 1'b0;
        #1;
        outs = {busy, done, err, out_valid, out_data, out_last, code_we, code_sym, code_val, code_len};
        checks++;
        if (outs !== 43'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || err) bad++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done || err) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_no_pulse: pulses %0d want 0", bad); end
        for (int i = 0; i < 16; i++) begin
            bits_we = 1'b1; bits_idx = 4'(i); bits_val = DC_CNT[i];
            @(posedge clk); #1;
        end
        bits_we = 1'b0;
        run_op(100, 200, -1);
        nbad = 0;
        for (int i = 0; i < 33; i++) if (got_b[i] !== EXP_DC[i]) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0 || done_n !== 1) begin
            errors++; $display("FAIL mid_restart: size %0d bad %0d done %0d want 33 0 1", got_b.size(), nbad, done_n);
        end
    endtask

    task automatic test_busy_write;
        int nbad;
        run_op(100, 200, 20);
        nbad = 0;
        for (int i = 0; i < 33; i++) if (got_b[i] !== EXP_DC[i]) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0) begin
            errors++; $display("FAIL busy_wr_stream: size %0d bad %0d want 33 0", got_b.size(), nbad);
        end
        run_op(100, 200, -1);
        nbad = 0;
        for (int i = 0; i < 33; i++) if (got_b[i] !== EXP_DC[i]) nbad++;
        checks++;
        if (got_b.size() !== 33 || nbad !== 0 || got_s.size() !== 12) begin
            errors++; $display("FAIL busy_wr_next: size %0d bad %0d codes %0d want 33 0 12",
                               got_b.size(), nbad, got_s.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bits_we = 1'b0; bits_idx = 4'd0; bits_val = 8'd0;
        val_we = 1'b0; val_idx = 8'd0; val_data = 8'd0;
        start = 1'b0; tc = 4'd0; th = 4'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_dc_stream();
        test_invalid();
        test_zero_then_valid();
        test_backpressure();
        test_reset_mid();
        test_busy_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dht_segment_writer.md
Name: dht_segment_writer

Overview:
- Encoder-side counterpart of the DHT decoder. Takes a Huffman table as 16 BITS counts plus HUFFVAL symbols, loaded through a write port.
- Validates the table, then streams the complete JPEG DHT marker segment as bytes: FFC4, Lh, Tc/Th, 16 counts, symbols.
- While streaming the symbols, emits the canonical code for each symbol (code and length) so the entropy encoder can fill its lookup table.
- Sits between the table-configuration logic and the JPEG header byte multiplexer.

Parameters:
MAX_SYMS, 256, depth of the HUFFVAL store; a total symbol count above this is an error
SYM_IDX_W, 8, width of the symbol index; must be at least clog2(MAX_SYMS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bits_we  in  1  write one BITS count
bits_idx  in  4  count index (code length minus 1)
bits_val  in  8  number of codes of length bits_idx+1
val_we  in  1  write one HUFFVAL symbol
val_idx  in  SYM_IDX_W  symbol position in canonical order
val_data  in  8  symbol value
start  in  1  begin validate and emit
tc  in  4  table class (0 = DC, 1 = AC)
th  in  4  table destination id
busy  out  1  high from accepted start until done/err
done  out  1  one-cycle pulse after the last byte handshake
err  out  1  one-cycle pulse when the table is invalid
out_valid  out  1  byte stream valid
out_ready  in  1  byte stream ready
out_data  out  8  segment byte
out_last  out  1  high with the final segment byte
code_we  out  1  code table write strobe
code_sym  out  8  symbol being coded
code_val  out  16  canonical code, right-justified
code_len  out  5  code length, 1..16

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n. On reset, all outputs are 0, the FSM goes to IDLE, and the BITS counts clear to 0. HUFFVAL contents are not reset.
- Reset mid-operation: the stream aborts immediately. No done or err is generated.
- Table writes: accepted only in IDLE; writes while busy are ignored. bits_we and val_we may both assert in the same cycle.
- start: sampled only in IDLE. tc/th are captured on acceptance. busy rises the next cycle.
- FSM states: IDLE -> CHECK -> HDR (5 bytes) -> BITS (16 bytes) -> VALS (N bytes) -> DONE -> IDLE.
- CHECK: 16 cycles, one length L per cycle, L = 1..16.
  - N += cnt[L].
  - Uses a 17-bit register code, starting at 0. If cnt[L] > 0 and code + cnt[L] >= 2^L, set err (overflow, or all-ones code).
  - Then code = (code + cnt[L]) << 1.
- CHECK end: if N == 0 or N > MAX_SYMS, set err.
  - On err: pulse err for 1 cycle, drop busy, return to IDLE. No byte is emitted.
- Header bytes: FF, C4, Lh[15:8], Lh[7:0], {tc,th}, where Lh = 19 + N.
- Then cnt[1..16], then HUFFVAL[0..N-1]. Total 21 + N bytes.
- Byte stream handshake: a byte transfers when out_valid and out_ready are both high. While out_ready is low, out_data and out_last hold stable. out_valid never drops mid-segment. out_valid rises the cycle after CHECK completes. out_last is high only on HUFFVAL[N-1].
- Code generation runs concurrently with VALS. A length pointer skips lengths whose count is 0, one cycle per skipped length, with out_valid held low during the skip. This is permitted only before a VALS byte, never mid-header.
  - On each symbol handshake: code_we=1 with code_sym = the byte, code_val = cur_code, code_len = L. Then cur_code++.
  - When the remaining count for L reaches 0: cur_code <<= 1 and L advances.
- done pulses in the cycle after the last handshake. busy falls with done.
- start asserted during done is ignored.

Decomposition:
- Shared package jpeg_pkg:
  - marker constants M_SOI, M_DHT = 8'hC4, M_PREFIX = 8'hFF;
  - enum dht_wr_state_t;
  - typedef huff_code_t = struct {logic [15:0] code; logic [4:0] len;}.
- One sub-module: dht_canon_gen. It holds the length pointer, remaining count and cur_code; it takes advance/init and produces code_val/code_len/skip. CHECK reuses its adder.

Test Plan:
- Standard luminance DC table: cnt = {0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0}, symbols 0..11, tc=0, th=0, out_ready=1.
  - Bytes: FF C4 00 1F 00 00 01 05 01 01 01 01 01 01 00 00 00 00 00 00 00 then 00..0B. out_last on 0B.
  - Codes: sym0 = 00/2, sym1 = 010/3, sym5 = 110/3, sym6 = 1110/4, sym11 = 111111110/9.
  - Total 33 bytes; done pulses 1 cycle after the last byte.
- Invalid table, cnt[1] = 2 (two 1-bit codes, all-ones): err pulses 1 cycle after CHECK. out_valid stays 0 and no code_we.
- All counts 0: err pulses, no bytes. A subsequent valid start works normally.
- Back-pressure: random out_ready at 30% duty on the DC table. The byte sequence is identical, data stays stable while stalled, and code_we count = 12.
- Reset mid-VALS (after the 25th byte): all outputs go to 0 within the reset assertion, with no done/err. After re-start, the stream is complete with BITS counts reloaded by the bench.
- Writes during busy: bits_we with cnt[2]=9 while streaming leaves the stream unchanged, and the next start still uses the original counts.
